// File: rtl/mixcol_pack_sequencer_if.sv
// mixcol_pack_sequencer_if: ALU lane-pair input and assembled-state output bus
interface mixcol_pack_sequencer_if;
  logic inValid, inReady, outValid, outReady, mcModeOut;
  logic [31:0] aluResult0, aluResult1;
  logic [127:0] stateOut;
  modport master (
    input inValid, aluResult0, aluResult1, outReady,
    output inReady, outValid, stateOut, mcModeOut
  );
  modport slave (
    output inValid, aluResult0, aluResult1, outReady,
    input inReady, outValid, stateOut, mcModeOut
  );
endinterface

// File: rtl/mixcol_pack_sequencer.sv
// mixcol_pack_sequencer: collects two lane-pair beats into a 128-bit AES state, optional counter via BLOCK_COUNT_EN
module mixcol_pack_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mcMode,
  input  logic abort,
  mixcol_pack_sequencer_if.master bus,
  output logic busy,
  output logic errStartBusy,
  output logic [COUNT_W-1:0] blockCount
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, OUT} state_t;
  state_t st, nxt;
  logic mode, take0, take1;
  logic [31:0] c0, c1;
  logic [127:0] cols, mc;
  assign busy = st != IDLE;
  assign bus.inReady = st == BEAT0 || st == BEAT1;
  assign bus.outValid = st == OUT;
  assign bus.mcModeOut = busy & mode;
  assign take0 = st == BEAT0 && bus.inValid && !abort;
  assign take1 = st == BEAT1 && bus.inValid && !abort;
  assign cols = {c0, c1, bus.aluResult0, bus.aluResult1};
  always_comb begin
    nxt = st;
    case (st)
      IDLE:  if (start) nxt = BEAT0;
      BEAT0: if (bus.inValid) nxt = BEAT1;
      BEAT1: if (bus.inValid) nxt = OUT;
      OUT:   if (bus.outReady) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // row r of the MixColumns layout gathers byte r of every column
  always_comb begin
    mc = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mc[127-32*r-8*c -: 8] = cols[127-32*c-8*r -: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      mode <= 1'b0;
      c0 <= '0;
      c1 <= '0;
      bus.stateOut <= '0;
      errStartBusy <= 1'b0;
    end else begin
      st <= nxt;
      errStartBusy <= start && busy;
      if (st == IDLE && start && !abort) mode <= mcMode;
      if (take0) {c0, c1} <= {bus.aluResult0, bus.aluResult1};
      if (take1) bus.stateOut <= mode ? mc : cols;
    end
`ifdef BLOCK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blockCount <= '0;
    else if (st == OUT && bus.outReady && !abort) blockCount <= blockCount + COUNT_W'(1);
`else
  assign blockCount = '0;
`endif
endmodule

// File: doc/mixcol_pack_sequencer.md
Name: mixcol_pack_sequencer

Overview:
Sequences the two-lane ALU result path into a full 128-bit AES state.
- Collects two beats of lane-pair results (columns 0/1, then columns 2/3).
- Drives the packing-unit mode select during collection.
- In MixColumns mode, transposes columns into row-major order.
- Presents the assembled state to the vector register writeback with a valid/ready handshake.
- Sits between the dual-lane ALU and the register-file write port.

Parameters:
COUNT_W, 16, width of the optional completed-block counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin collecting one block; sampled only in IDLE
mcMode  input  1  layout for this block, latched on accepted start: 1 = MixColumns (row-major), 0 = linear
abort  input  1  discard the in-flight block and return to IDLE
inValid  input  1  ALU lane pair valid
inReady  output  1  sequencer accepts a lane pair
aluResult0  input  32  lane 0 result (even column)
aluResult1  input  32  lane 1 result (odd column)
mcModeOut  output  1  mode select to packing unit
outValid  output  1  assembled state valid
outReady  input  1  writeback accepts state
stateOut  output  128  assembled state
busy  output  1  state != IDLE
errStartBusy  output  1  one-cycle pulse when start is asserted outside IDLE
blockCount  output  COUNT_W  completed-block count (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - All column registers, stateOut, outValid, inReady, mcModeOut, busy, errStartBusy and blockCount are 0.
  - Latched mode is 0.
- FSM states: IDLE, BEAT0, BEAT1, OUT.
- IDLE:
  - inReady = 0.
  - start = 1 latches mcMode; next state BEAT0.
- BEAT0:
  - inReady = 1.
  - On inValid & inReady: c0 <= aluResult0, c1 <= aluResult1; next state BEAT1.
- BEAT1:
  - inReady = 1.
  - On handshake: c2 <= aluResult0, c3 <= aluResult1; next state OUT.
- OUT:
  - outValid = 1; stateOut is held stable until outReady.
  - On outValid & outReady: next state IDLE; blockCount increments.
- Back-to-back behaviour:
  - BEAT0 and BEAT1 accept on consecutive cycles.
  - outValid rises in the cycle after the BEAT1 handshake.
  - Minimum block time is 4 cycles: start, beat0, beat1, out, with outReady held high.
- stateOut assembly, registered on entry to OUT; byte r of column c = c[31-8r -: 8]:
  - Mode 1: row r = {c0 byte r, c1 byte r, c2 byte r, c3 byte r}; stateOut = {row0, row1, row2, row3}.
  - Mode 0: stateOut = {c0, c1, c2, c3}.
- mcModeOut: equals latched mode in BEAT0/BEAT1/OUT; 0 in IDLE.
- Inputs are ignored when not in the relevant state:
  - inValid in IDLE or OUT has no effect.
  - start outside IDLE has no effect on the FSM and pulses errStartBusy for 1 cycle.
- abort:
  - Highest priority. In any state, the next state is IDLE.
  - outValid drops the next cycle, and the block is not counted.
  - abort coincident with an OUT handshake: handshake completes (state was consumed); counter does NOT increment.
  - abort with start in IDLE: start is ignored.
- stateOut retains its last value in IDLE; consumers qualify it with outValid.
- Counter wraps from 2^COUNT_W-1 to 0.
- Reset mid-block: immediate return to the reset values; no partial output.

Optional Feature:
BLOCK_COUNT_EN
- Defined: blockCount is a COUNT_W-bit register incremented on each completed OUT handshake (not aborted); it wraps.
- Undefined: no counter register; blockCount is tied to 0.

Test Plan:
- MixColumns block:
  - Stimulus: start with mcMode=1, beats (0x00112233, 0x44556677) then (0x8899AABB, 0xCCDDEEFF), outReady=1.
  - Response: stateOut = 0x004488CC_115599DD_2266AAEE_3377BBFF; outValid for 1 cycle; mcModeOut=1 throughout.
- Linear block:
  - Stimulus: same data with mcMode=0.
  - Response: stateOut = 0x00112233_44556677_8899AABB_CCDDEEFF; mcModeOut=0.
- Backpressure:
  - Stimulus: outReady=0 for 5 cycles after outValid; inValid toggles meanwhile.
  - Response: stateOut and outValid stable; inReady=0; no data captured; completes on the first outReady=1.
- Abort:
  - Stimulus: abort in BEAT1 after beat0 accepted.
  - Response: next cycle IDLE, busy=0, no outValid; the following block outputs correctly with no stale c0/c1.
- Start while busy / reset:
  - Stimulus: start in BEAT0; then rst_n low in OUT.
  - Response: errStartBusy is a single-cycle pulse with the FSM unaffected; the reset clears outValid immediately (asynchronously).
- Counter (BLOCK_COUNT_EN, COUNT_W=2):
  - Stimulus: 5 completed blocks plus 1 aborted.
  - Response: blockCount = 1.
